// File: rtl/axis_strip_head_end.sv
// axis_strip_head_end: strips the head (first) and end (tlast) words from an
// AXI-Stream packet and forwards only the payload. tlast is moved onto the
// final payload beat. The captured head and end words are held on sideband
// outputs, each with a one-cycle update pulse.
// Optional statistics counters are enabled by defining AXIS_STRIP_HEAD_END_STAT_EN.
module axis_strip_head_end #(
    parameter int unsigned DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [DSIZE-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             in_tlast,
    output logic [DSIZE-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic [DSIZE-1:0] head_value,
    output logic             head_vld,
    output logic [DSIZE-1:0] end_value,
    output logic             end_vld,
    output logic             short_err,
    output logic             empty_pkt
`ifdef AXIS_STRIP_HEAD_END_STAT_EN
    ,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      empty_cnt
`endif
);

    // StHold implies the hold register contains a valid payload beat.
    typedef enum logic [1:0] {StHead, StEmpty, StHold} state_e;

    state_e           state_q, state_d;
    logic [DSIZE-1:0] hold_q, hold_d;
    logic [DSIZE-1:0] head_value_q, head_value_d;
    logic [DSIZE-1:0] end_value_q, end_value_d;
    logic             head_vld_q, head_vld_d;
    logic             end_vld_q, end_vld_d;
    logic             short_err_q, short_err_d;
    logic             empty_pkt_q, empty_pkt_d;
    logic             accept;

    // In StHold, in_tready already includes out_tready, so accept == output fire.
    assign accept = in_tvalid & in_tready;

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StHead;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        head_value_d = head_value_q;
        end_value_d  = end_value_q;
        head_vld_d   = 1'b0;
        end_vld_d    = 1'b0;
        short_err_d  = 1'b0;
        empty_pkt_d  = 1'b0;
        unique case (state_q)
            StHead: begin
                if (accept) begin
                    head_value_d = in_tdata;
                    head_vld_d   = 1'b1;
                    if (in_tlast) begin
                        short_err_d = 1'b1;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            StEmpty: begin
                if (accept) begin
                    if (in_tlast) begin
                        end_value_d = in_tdata;
                        end_vld_d   = 1'b1;
                        empty_pkt_d = 1'b1;
                        state_d     = StHead;
                    end else begin
                        hold_d  = in_tdata;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (accept) begin
                    if (in_tlast) begin
                        end_value_d = in_tdata;
                        end_vld_d   = 1'b1;
                        state_d     = StHead;
                    end else begin
                        hold_d = in_tdata;
                    end
                end
            end
            default: state_d = StHead;
        endcase
    end

    // Outputs: the held beat is only released alongside its successor so tlast can follow it.
    always_comb begin
        in_tready  = enable;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        out_tdata  = hold_q;
        if (state_q == StHold) begin
            in_tready  = out_tready & enable;
            out_tvalid = in_tvalid & enable;
            out_tlast  = in_tlast;
        end
    end

    // Datapath and pulse registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            hold_q       <= '0;
            head_value_q <= '0;
            end_value_q  <= '0;
            head_vld_q   <= 1'b0;
            end_vld_q    <= 1'b0;
            short_err_q  <= 1'b0;
            empty_pkt_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            head_value_q <= head_value_d;
            end_value_q  <= end_value_d;
            head_vld_q   <= head_vld_d;
            end_vld_q    <= end_vld_d;
            short_err_q  <= short_err_d;
            empty_pkt_q  <= empty_pkt_d;
        end
    end

    assign head_value = head_value_q;
    assign head_vld   = head_vld_q;
    assign end_value  = end_value_q;
    assign end_vld    = end_vld_q;
    assign short_err  = short_err_q;
    assign empty_pkt  = empty_pkt_q;

`ifdef AXIS_STRIP_HEAD_END_STAT_EN
    logic [15:0] pkt_cnt_q, err_cnt_q, empty_cnt_q;

    // Event counters, wrapping naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            empty_cnt_q <= '0;
        end else begin
            if (end_vld_q)   pkt_cnt_q   <= pkt_cnt_q + 16'd1;
            if (short_err_q) err_cnt_q   <= err_cnt_q + 16'd1;
            if (empty_pkt_q) empty_cnt_q <= empty_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign empty_cnt = empty_cnt_q;
`endif

endmodule
